// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares the single line-wide pmem port between icache and dcache.
// Registered grant, one dead RELEASE cycle after every transfer, sticky watchdog.

module lc3b_mem_arbiter #(
    parameter bit          D_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic [127:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
    localparam bit         WDOG_EN     = (TIMEOUT != 0);

    state_e     state_q, state_d;
    logic       last_d_q, last_d_d;
    logic [7:0] timer_q, timer_d;
    logic       err_q, err_d;

    logic       i_req;
    logic       d_req;
    logic       pick_d;
    logic [7:0] timer_inc;

    assign i_req  = i_read;
    assign d_req  = d_read | d_write;
    assign pick_d = D_PRIORITY | ~last_d_q;

    // State, fairness pointer, watchdog timer and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            timer_q  <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    // Next-state: arbitrate in IDLE, wait for pmem_resp while serving, then one dead cycle.
    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        timer_d   = timer_q;
        err_d     = err_q;
        timer_inc = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = pick_d ? SERVE_D : SERVE_I;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
                if (i_req || d_req) begin
                    timer_d = 8'd0;
                end
            end
            SERVE_I, SERVE_D: begin
                timer_d = timer_inc;
                if (WDOG_EN && (timer_inc == TIMEOUT_CNT)) begin
                    err_d = 1'b1;
                end
                if (pmem_resp) begin
                    last_d_d = (state_q == SERVE_D);
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output routing: only the granted requester sees pmem traffic and its response.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'd0;
        i_resp       = 1'b0;
        i_rdata      = 128'd0;
        d_resp       = 1'b0;
        d_rdata      = 128'd0;
        unique case (state_q)
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address & 16'hFFF0;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                end
            end
            SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address & 16'hFFF0;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = pmem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign err_timeout = err_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter: directed + random checks of two arbiter instances
// (A: round-robin, TIMEOUT=4; B: data priority, watchdog off) against a reference model.

module tb_lc3b_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    logic         i_read[2], d_read[2], d_write[2], pmem_resp[2];
    logic [15:0]  i_address[2], d_address[2];
    logic [127:0] d_wdata[2], pmem_rdata[2];
    logic [127:0] i_rdata[2], d_rdata[2], pmem_wdata[2];
    logic         i_resp[2], d_resp[2], pmem_read[2], pmem_write[2], err_timeout[2];
    logic [15:0]  pmem_address[2];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who owns memory (0 none, 1 I, 2 D), dead cycle pending, etc.
    int owner[2];
    bit cool[2];
    bit last_was_d[2];
    int wait_cyc[2];
    bit err_m[2];
    int lat[2];
    bit i_done[2], d_done[2];

    bit auto_on;
    int req_pct;
    int max_lat;
    logic [3:0] seq[2];
    int nrec[2];
    int b_iresp;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    lc3b_mem_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read[0]), .i_address(i_address[0]),
        .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_read(d_read[0]), .d_write(d_write[0]),
        .d_address(d_address[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_address(pmem_address[0]), .pmem_wdata(pmem_wdata[0]),
        .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0]),
        .err_timeout(err_timeout[0])
    );

    lc3b_mem_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read[1]), .i_address(i_address[1]),
        .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_read(d_read[1]), .d_write(d_write[1]),
        .d_address(d_address[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_address(pmem_address[1]), .pmem_wdata(pmem_wdata[1]),
        .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1]),
        .err_timeout(err_timeout[1])
    );

    function automatic bit dprio(input int k);
        return (k == 1);
    endfunction

    function automatic int tmo(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input int k,
                         input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s[%0d] got=%0h want=%0h", tag, k, got, want);
        end
    endtask

    task automatic model_reset(input int k);
        owner[k]      = 0;
        cool[k]       = 1'b0;
        last_was_d[k] = 1'b1;
        wait_cyc[k]   = 0;
        err_m[k]      = 1'b0;
        i_done[k]     = 1'b0;
        d_done[k]     = 1'b0;
    endtask

    task automatic clear_inputs(input int k);
        i_read[k]     = 1'b0;
        d_read[k]     = 1'b0;
        d_write[k]    = 1'b0;
        pmem_resp[k]  = 1'b0;
        i_address[k]  = 16'h0;
        d_address[k]  = 16'h0;
        d_wdata[k]    = 128'd0;
        pmem_rdata[k] = 128'd0;
    endtask

    // expected outputs this cycle, from who owns memory and the live inputs
    task automatic check_outputs(input int k);
        logic [4:0]   ctl;
        logic [15:0]  a;
        logic [127:0] wd, ird, drd;
        ctl = 5'b0;
        a   = 16'h0;
        wd  = 128'd0;
        ird = 128'd0;
        drd = 128'd0;
        if (owner[k] == 1) begin
            ctl[4] = 1'b1;
            a      = {i_address[k][15:4], 4'h0};
            if (pmem_resp[k]) begin
                ctl[2] = 1'b1;
                ird    = pmem_rdata[k];
            end
        end else if (owner[k] == 2) begin
            ctl[4] = d_read[k] && !d_write[k];
            ctl[3] = d_write[k];
            a      = {d_address[k][15:4], 4'h0};
            wd     = d_wdata[k];
            if (pmem_resp[k]) begin
                ctl[1] = 1'b1;
                drd    = pmem_rdata[k];
            end
        end
        ctl[0] = err_m[k];
        check("ctl", k,
              128'({pmem_read[k], pmem_write[k], i_resp[k], d_resp[k], err_timeout[k]}),
              128'(ctl));
        check("addr", k, 128'(pmem_address[k]), 128'(a));
        check("wdata", k, pmem_wdata[k], wd);
        check("i_rdata", k, i_rdata[k], ird);
        check("d_rdata", k, d_rdata[k], drd);
    endtask

    // advance the model across the coming rising edge
    task automatic model_update(input int k);
        bit ir, dr;
        if (!reset_n) begin
            model_reset(k);
        end else if (cool[k]) begin
            cool[k] = 1'b0;
        end else if (owner[k] == 0) begin
            ir = i_read[k];
            dr = d_read[k] || d_write[k];
            if (ir && dr) owner[k] = (dprio(k) || !last_was_d[k]) ? 2 : 1;
            else if (ir) owner[k] = 1;
            else if (dr) owner[k] = 2;
            if (owner[k] != 0) begin
                wait_cyc[k] = 0;
                lat[k]      = $urandom_range(0, max_lat);
            end
        end else begin
            if (wait_cyc[k] < 255) wait_cyc[k]++;
            if (tmo(k) != 0 && wait_cyc[k] >= tmo(k)) err_m[k] = 1'b1;
            if (pmem_resp[k]) begin
                last_was_d[k] = (owner[k] == 2);
                if (owner[k] == 1) i_done[k] = 1'b1;
                else d_done[k] = 1'b1;
                owner[k] = 0;
                cool[k]  = 1'b1;
            end
        end
    endtask

    // protocol-following random requesters and memory
    task automatic drive(input int k);
        int kind;
        if (i_done[k]) begin
            i_read[k] = 1'b0;
            i_done[k] = 1'b0;
        end else if (!i_read[k] && $urandom_range(0, 99) < req_pct) begin
            i_read[k]    = 1'b1;
            i_address[k] = 16'($urandom());
        end
        if (d_done[k]) begin
            d_read[k]  = 1'b0;
            d_write[k] = 1'b0;
            d_done[k]  = 1'b0;
        end else if (!(d_read[k] || d_write[k]) && $urandom_range(0, 99) < req_pct) begin
            kind         = $urandom_range(0, 3);
            d_read[k]    = (kind != 2);
            d_write[k]   = (kind >= 2);
            d_address[k] = 16'($urandom());
            d_wdata[k]   = rnd128();
        end
        pmem_rdata[k] = rnd128();
        if (owner[k] != 0) begin
            if (lat[k] == 0) begin
                pmem_resp[k] = 1'b1;
            end else begin
                pmem_resp[k] = 1'b0;
                lat[k]--;
            end
        end else begin
            pmem_resp[k] = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic record(input int k, input bit is_d);
        if (nrec[k] < 4) begin
            seq[k]  = {seq[k][2:0], is_d};
            nrec[k] = nrec[k] + 1;
        end
    endtask

    // one clock: check, observe, predict, then drive the next cycle at the falling edge
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_outputs(k);
            if (i_resp[k] === 1'b1) record(k, 1'b0);
            if (d_resp[k] === 1'b1) record(k, 1'b1);
        end
        if (i_resp[1] === 1'b1) b_iresp++;
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
        if (auto_on) begin
            for (int k = 0; k < 2; k++) drive(k);
        end
    endtask

    initial begin
        auto_on = 1'b0;
        req_pct = 40;
        max_lat = 2;
        b_iresp = 0;
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            model_reset(k);
            seq[k]  = 4'h0;
            nrec[k] = 0;
        end
        reset_n = 1'b0;

        // reset with icache request held: everything quiet
        i_read[0]    = 1'b1;
        i_address[0] = 16'hABCD;
        step();
        step();
        reset_n = 1'b1;
        step();
        #1;
        check("rst_pread", 0, 128'(pmem_read[0]), 128'(1'b1));
        check("rst_paddr", 0, 128'(pmem_address[0]), 128'(16'hABC0));
        pmem_resp[0]  = 1'b1;
        pmem_rdata[0] = 128'hDEADBEEF_00000000_00000000_DEADBEEF;
        #1;
        check("i_resp", 0, 128'({i_resp[0], d_resp[0]}), 128'(2'b10));
        check("i_rdata_val", 0, i_rdata[0], 128'hDEADBEEF_00000000_00000000_DEADBEEF);
        step();
        i_read[0]    = 1'b0;
        pmem_resp[0] = 1'b0;
        step();

        // dcache write-back with unaligned address
        d_write[0]   = 1'b1;
        d_address[0] = 16'h1237;
        d_wdata[0]   = 128'h0123456789ABCDEF_FEDCBA9876543210;
        step();
        #1;
        check("wb_strobes", 0, 128'({pmem_read[0], pmem_write[0]}), 128'(2'b01));
        check("wb_addr", 0, 128'(pmem_address[0]), 128'(16'h1230));
        check("wb_wdata", 0, pmem_wdata[0], 128'h0123456789ABCDEF_FEDCBA9876543210);
        step();
        pmem_resp[0]  = 1'b1;
        pmem_rdata[0] = rnd128();
        #1;
        check("wb_resp", 0, 128'({pmem_read[0], d_resp[0], i_resp[0]}), 128'(3'b010));
        step();
        d_write[0]   = 1'b0;
        pmem_resp[0] = 1'b0;
        step();
        step();

        // continuous requests from reset: A alternates, B always grants D
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            i_read[k]    = 1'b1;
            i_address[k] = 16'h2000 + 16'(k);
            d_read[k]    = 1'b1;
            d_address[k] = 16'h3000 + 16'(k);
            seq[k]       = 4'h0;
            nrec[k]      = 0;
        end
        b_iresp = 0;
        step();
        reset_n = 1'b1;
        req_pct = 100;
        auto_on = 1'b1;
        for (int c = 0; c < 300 && !(nrec[0] >= 4 && nrec[1] >= 4); c++) step();
        check("rr_count", 0, 128'(nrec[0]), 128'(4));
        check("rr_order", 0, 128'(seq[0]), 128'(4'b0101));
        check("dp_count", 1, 128'(nrec[1]), 128'(4));
        check("dp_order", 1, 128'(seq[1]), 128'(4'b1111));
        check("dp_starve", 1, 128'(b_iresp), 128'(0));

        // random traffic including spurious pmem_resp
        req_pct = 40;
        for (int c = 0; c < 600; c++) step();

        // watchdog: A trips after 4 cycles, B has it disabled
        auto_on = 1'b0;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) clear_inputs(k);
        step();
        reset_n      = 1'b1;
        i_read[0]    = 1'b1;
        i_address[0] = 16'h4321;
        i_read[1]    = 1'b1;
        i_address[1] = 16'h8888;
        step();
        for (int n = 0; n < 6; n++) begin
            #1;
            check("wd_err", 0, 128'(err_timeout[0]), 128'(n >= 4));
            check("wd_off", 1, 128'(err_timeout[1]), 128'(1'b0));
            step();
        end
        for (int k = 0; k < 2; k++) begin
            pmem_resp[k]  = 1'b1;
            pmem_rdata[k] = rnd128();
        end
        step();
        for (int k = 0; k < 2; k++) clear_inputs(k);
        step();
        step();
        #1;
        check("wd_sticky", 0, 128'(err_timeout[0]), 128'(1'b1));
        step();

        // asynchronous reset while serving the dcache
        d_write[0]   = 1'b1;
        d_address[0] = 16'hBEEF;
        d_wdata[0]   = 128'h55AA55AA_0F0F0F0F_F0F0F0F0_AA55AA55;
        step();
        #1;
        check("rst_pre", 0, 128'(pmem_write[0]), 128'(1'b1));
        reset_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("rst_async", 0,
              128'({pmem_read[0], pmem_write[0], d_resp[0], err_timeout[0], pmem_address[0]}),
              128'(0));
        check("rst_wdata", 0, pmem_wdata[0], 128'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        pmem_resp[0]  = 1'b1;
        pmem_rdata[0] = rnd128();
        #1;
        check("late_resp", 0, 128'({d_resp[0], pmem_write[0]}), 128'(2'b00));
        step();
        #1;
        check("restart", 0, 128'({pmem_write[0], d_resp[0]}), 128'(2'b11));
        step();
        d_write[0]   = 1'b0;
        pmem_resp[0] = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
